// File: rtl/fpa_stream_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : fpa_stream_accumulator_if
// Brief    : Operand stream, adder drive/return and sum handshake bundle.
// Revision : 1.0
// ============================================================================
interface fpa_stream_accumulator_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_o;
    logic             add_of;
    logic             sum_valid;
    logic             sum_ready;
    logic [31:0]      sum_data;
    logic             sum_of;
    logic             busy;

    // Accumulator side.
    modport slave (
        input  start, len, in_valid, in_data, add_o, add_of, sum_ready,
        output in_ready, add_a, add_b, sum_valid, sum_data, sum_of, busy
    );

    // Producer / adder / consumer side.
    modport master (
        output start, len, in_valid, in_data, add_o, add_of, sum_ready,
        input  in_ready, add_a, add_b, sum_valid, sum_data, sum_of, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fpa_stream_accumulator
// Brief    : Left-folds a length-tagged FP32 stream through an external adder.
// Revision : 1.0
// ============================================================================
module fpa_stream_accumulator #(
    parameter int LEN_W = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    fpa_stream_accumulator_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      acc_q,   acc_d;
    logic             of_q,    of_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= 32'h0000_0000;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            of_q    <= of_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        of_d    = of_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    cnt_d   = '0;
                    acc_d   = 32'h0000_0000;
                    of_d    = 1'b0;
                    state_d = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = bus.add_o;
                    of_d  = of_q | bus.add_of;
                    cnt_d = cnt_q + LEN_W'(1);
                    // Stop one short of len_q so cnt never has to hold 2^LEN_W.
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.sum_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_ACCUM);
        bus.sum_valid = (state_q == S_DONE);
        bus.sum_data  = (state_q == S_DONE) ? acc_q : 32'h0000_0000;
        bus.sum_of    = (state_q == S_DONE) ? of_q  : 1'b0;
        bus.busy      = (state_q != S_IDLE);
        bus.add_a     = acc_q;
        // Zero B outside ACCUM so the adder simply echoes the running sum.
        bus.add_b     = (state_q == S_ACCUM) ? bus.in_data : 32'h0000_0000;
    end
endmodule
`default_nettype wire

// File: tb/tb_fpa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpa_stream_accumulator
// Brief    : Scoreboarded bench with a behavioural fpa adder model.
// Revision : 1.0
// ============================================================================
module tb_fpa_stream_accumulator;
    logic clk;
    logic rst;
    logic of_force;
    int   n_cmp;
    int   n_err;
    logic [32:0] exp_q[$];

    fpa_stream_accumulator_if #(.LEN_W(8)) bus ();

    fpa_stream_accumulator #(.LEN_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f32_to_real(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'({24'd0, f[30:23]}) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        real         a;
        int          e;
        logic        s;
        logic [22:0] man;
        if (r == 0.0) return 32'h0000_0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        man = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e + 127), man};
    endfunction

    // Behavioural stand-in for the combinational fpa adder.
    assign bus.add_o  = real_to_f32(f32_to_real(bus.add_a) + f32_to_real(bus.add_b));
    assign bus.add_of = of_force;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.sum_valid && bus.sum_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_sum", 64'(bus.sum_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("sb_sum", 64'({bus.sum_of, bus.sum_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sum_i;
        int          v;
        logic [31:0] held;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        of_force = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.sum_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
        check("rst_sum_data",  64'(bus.sum_data),  64'd0);
        check("rst_sum_of",    64'(bus.sum_of),    64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_add_a",     64'(bus.add_a),     64'd0);
        check("rst_add_b",     64'(bus.add_b),     64'd0);
        rst = 1'b0;
        tick();

        // Basic sum 1+2+3.
        exp_q.push_back({1'b0, 32'h40C0_0000});
        do_start(8'd3);
        check("basic_in_ready", 64'(bus.in_ready), 64'd1);
        send(32'h3F80_0000);
        send(32'h4000_0000);
        send(32'h4040_0000);
        check("basic_sum_valid_k1", 64'(bus.sum_valid), 64'd1);
        tick();
        check("basic_idle", 64'(bus.busy), 64'd0);

        // Zero length.
        exp_q.push_back({1'b0, 32'h0000_0000});
        do_start(8'd0);
        check("zlen_in_ready", 64'(bus.in_ready), 64'd0);
        check("zlen_sum_valid", 64'(bus.sum_valid), 64'd1);
        tick();
        check("zlen_idle", 64'(bus.busy), 64'd0);

        // Input bubbles and output backpressure.
        bus.sum_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_0000});
        do_start(8'd2);
        send(32'h3F80_0000);
        for (int i = 0; i < 3; i++) begin
            check("bubble_acc", 64'(bus.add_a), 64'h3F80_0000);
            tick();
        end
        send(32'hBF80_0000);
        for (int i = 0; i < 4; i++) begin
            check("bp_sum_valid", 64'(bus.sum_valid), 64'd1);
            check("bp_sum_data",  64'(bus.sum_data),  64'd0);
            tick();
        end
        bus.sum_ready = 1'b1;
        tick();
        check("bp_idle", 64'(bus.busy), 64'd0);

        // Sticky overflow, then cleared on next start.
        exp_q.push_back({1'b1, 32'h40C0_0000});
        do_start(8'd3);
        send(32'h3F80_0000);
        of_force = 1'b1;
        send(32'h4000_0000);
        of_force = 1'b0;
        send(32'h4040_0000);
        tick();
        exp_q.push_back({1'b0, 32'h3F80_0000});
        do_start(8'd1);
        send(32'h3F80_0000);
        tick();

        // Reset mid-stream discards the partial sum.
        do_start(8'd5);
        send(32'h3F80_0000);
        send(32'h4000_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",      64'(bus.busy),      64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        check("midrst_sum_valid", 64'(bus.sum_valid), 64'd0);
        check("midrst_acc",       64'(bus.add_a),     64'd0);
        exp_q.push_back({1'b0, 32'h40A0_0000});
        do_start(8'd1);
        send(32'h40A0_0000);
        tick();

        // Start while busy is ignored.
        exp_q.push_back({1'b0, 32'h4040_0000});
        do_start(8'd2);
        bus.start = 1'b1;
        bus.len   = 8'd9;
        tick();
        bus.start = 1'b0;
        check("busy_start_still_accum", 64'(bus.in_ready), 64'd1);
        send(32'h3F80_0000);
        send(32'h4000_0000);
        check("busy_start_done", 64'(bus.sum_valid), 64'd1);
        tick();

        // Random small integers with random bubbles.
        sum_i = 0;
        do_start(8'd6);
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(10, 1));
            sum_i += v;
            repeat ($urandom_range(2, 0)) tick();
            send(real_to_f32(real'(v)));
        end
        exp_q.push_back({1'b0, real_to_f32(real'(sum_i))});
        held = bus.sum_data;
        check("rand_done", 64'(bus.sum_valid), 64'd1);
        tick();

        repeat (3) tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("end_idle", 64'(bus.busy), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fpa_stream_accumulator.md
# fpa_stream_accumulator

Sequential front-end and result stage for the combinational single-precision adder `fpa`. It takes a length-tagged stream of IEEE 754 single-precision operands over a valid/ready handshake and feeds each operand to the adder together with the running sum. It captures the adder's result as the new running sum and presents the final sum, with a sticky overflow flag, on a second valid/ready handshake. The block sits directly upstream of `fpa` (drives `A`/`B`) and directly downstream of it (consumes `O`/`OF`).

## Interface
Parameters:
- `LEN_W`, default 8: width of the element-count field; max stream length 2^LEN_W − 1.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `start` input 1: one-cycle request to begin a stream; honoured only in IDLE.
- `len` input LEN_W: number of elements in the stream; sampled with `start`.
- `in_valid` input 1: `in_data` holds an operand.
- `in_ready` output 1: block accepts an operand this cycle.
- `in_data` input 32: IEEE 754 operand.
- `add_a` output 32: to `fpa.A`.
- `add_b` output 32: to `fpa.B`.
- `add_o` input 32: from `fpa.O`.
- `add_of` input 1: from `fpa.OF`.
- `sum_valid` output 1: final sum available.
- `sum_ready` input 1: consumer takes the sum.
- `sum_data` output 32: final sum.
- `sum_of` output 1: sticky OR of `add_of` over all accepted elements.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**:
  - `in_ready`=0, `sum_valid`=0.
  - On `start`: `len_q`←`len`, `acc`←32'h00000000, `cnt`←0, `of_q`←0.
  - Next state is DONE if `len`=0, otherwise ACCUM.
- **ACCUM**:
  - `in_ready`=1.
  - Accept when `in_valid`&&`in_ready`. On accept: `acc`←`add_o`, `of_q`←`of_q`|`add_of`, `cnt`←`cnt`+1.
  - If `cnt`=`len_q`−1 at the time of the accept, next state is DONE.
  - Cycles with `in_valid`=0 leave all state unchanged.
- **DONE**:
  - `sum_valid`=1; `sum_data`=`acc`; `sum_of`=`of_q`.
  - The sum is held stable until `sum_valid`&&`sum_ready`, then the FSM returns to IDLE.
- Adder drive (combinational):
  - `add_a`=`acc` in all states.
  - `add_b`=`in_data` in ACCUM, otherwise 32'h00000000. `fpa` returns A when B is zero, so `add_o` is benign when idle.
- `start` outside IDLE is ignored; `len` is not re-sampled.
- `cnt` is LEN_W bits wide and never wraps, because termination happens at `len_q`−1.
- The sum is exactly the left-fold ((0+x0)+x1)+…, using `fpa` semantics for NaN, Inf and zero; the block performs no rounding or special-case handling of its own.
- `rst` in any state: return to IDLE and clear `acc`, `cnt`, `len_q`, `of_q`. Any in-flight stream is discarded and no partial sum is emitted.

## Timing
- Reset values: `in_ready`=0, `sum_valid`=0, `sum_data`=0, `sum_of`=0, `busy`=0, `add_a`=0, `add_b`=0.
- `start` in cycle t puts the FSM in ACCUM (`in_ready`=1) at t+1, or in DONE (`sum_valid`=1) at t+1 when `len`=0.
- Throughput is one element per cycle. The adder path in_data→add_b→fpa→add_o→acc is single-cycle combinational.
- If the last element is accepted in cycle k, `sum_valid`=1 from k+1.
- If `sum_ready`=1 in the first DONE cycle, the FSM is in IDLE the following cycle, and a new `start` can be honoured there.
- `sum_ready` may be high before `sum_valid`; that has no effect.
- `in_ready` never depends combinationally on `in_valid`.

## Test plan
- **Basic sum**: `len`=3, operands 3F800000, 40000000, 40400000 on consecutive cycles → `sum_valid` 1 cycle after the 3rd accept, `sum_data`=40C00000, `sum_of`=0.
- **Zero length**: `start` with `len`=0 → `in_ready` stays 0, `sum_valid` at t+1, `sum_data`=00000000.
- **Input bubbles and output backpressure**: `len`=2, operands 3F800000 and BF800000, `in_valid` low for 3 cycles between them, `sum_ready` low for 4 cycles → `acc` is unchanged during the bubble; `sum_data`=00000000 and is held stable until `sum_ready`.
- **Sticky overflow**: `len`=3, adder model asserts `add_of` on the 2nd accept only → `sum_of`=1 at DONE; `of_q` resets to 0 on the next `start`.
- **Reset mid-stream**: `len`=5, `rst` after 2 accepts → next cycle `busy`=0, `in_ready`=0, `sum_valid`=0. A new stream of 1 element, 40A00000, then yields exactly 40A00000.
- **Start while busy**: `start` with `len`=9 pulsed during ACCUM of a `len`=2 stream → ignored; DONE occurs after 2 accepts.
